instr_queue: RTL



---
 rtl/instr_queue.sv | 80 ++++++++
 1 files changed

// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch: first-word-fall-through FIFO
// of {instruction, pc} with early-full back-pressure and a sticky drop flag.
module instr_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [31:0]       in_instruction,
    input  logic [31:0]       in_pc,
    input  logic              deq_ready,
    output logic              out_valid,
    output logic [31:0]       out_instruction,
    output logic [31:0]       out_pc,
    output logic              out_is_compressed,
    output logic              iq_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] HIGH_CNT = (ADDR_W + 1)'(DEPTH - MARGIN);

    logic [31:0]       mem_instr [DEPTH];
    logic [31:0]       mem_pc    [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_write;

    assign push      = (in_instruction != 32'd0);
    assign out_valid = (count != '0);
    assign pop       = out_valid && deq_ready;
    assign full      = (count == FULL_CNT);
    // When full, a simultaneous pop frees the head slot, which is also the tail slot.
    assign do_write  = push && (!full || pop);
    assign iq_full   = (count >= HIGH_CNT);

    assign out_instruction   = mem_instr[head];
    assign out_pc            = mem_pc[head];
    assign out_is_compressed = (mem_instr[head][1:0] != 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (do_write && !pop)
                count <= count + 1'b1;
            else if (pop && !do_write)
                count <= count - 1'b1;
            if (push && !do_write)
                overflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!flush && do_write) begin
            mem_instr[tail] <= in_instruction;
            mem_pc[tail]    <= in_pc;
        end
    end

endmodule
